// File: rtl/shift_seq_ctrl.sv
// Parallel-to-serial word controller: accepts an N-bit word, shifts it out LSB first,
// then idles GAP cycles. Define SHIFT_PARITY_EN to append one even-parity bit per word.
module shift_seq_ctrl #(
  parameter int N   = 4,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic [N-1:0] word_in,
  input  logic         word_valid,
  output logic         word_ready,
  output logic         q_out,
  output logic         frame_out,
  output logic         busy,
  output logic         done_out
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

`ifdef SHIFT_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

  state_t        state, state_nxt;
  logic [N-1:0]  shift_reg;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    gap_cnt;
  logic          armed;
  logic          accept;
  logic          last_bit;
  logic          gap_end;
`ifdef SHIFT_PARITY_EN
  logic          par_bit;
`endif

  assign accept   = word_valid & word_ready;
  assign last_bit = (bit_cnt == CW'(N - 1));
  assign gap_end  = (gap_cnt == 4'(GAP - 1));

  // NOTE: every output and next-state signal is given a default first so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    word_ready = 1'b0;
    q_out      = 1'b0;
    frame_out  = 1'b0;
    done_out   = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        word_ready = armed;
        if (accept) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        q_out     = shift_reg[0];
        frame_out = 1'b1;
`ifdef SHIFT_PARITY_EN
        if (last_bit) state_nxt = S_PAR;
`else
        done_out  = last_bit;
        if (last_bit) state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
`endif
      end
`ifdef SHIFT_PARITY_EN
      S_PAR: begin
        q_out     = par_bit;
        frame_out = 1'b1;
        done_out  = 1'b1;
        state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
      end
`endif
      S_GAP: begin
        if (gap_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      armed     <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (accept) begin
        shift_reg <= word_in;
        bit_cnt   <= '0;
      end else if (state == S_SHIFT) begin
        shift_reg <= shift_reg >> 1;
        // Hold at N-1 instead of wrapping; the counter is reloaded on the next accept.
        if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
      end
      gap_cnt <= (state == S_GAP) ? gap_cnt + 4'd1 : 4'd0;
    end
  end

`ifdef SHIFT_PARITY_EN
  // Parity is captured with the word, since the shift register is consumed while shifting.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in)  par_bit <= 1'b0;
    else if (accept)   par_bit <= ^word_in;
  end
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed testbench for shift_seq_ctrl: one instance with GAP=1 and one with GAP=0.
module tb_shift_seq_ctrl;

  localparam int N = 4;
  localparam int GAP = 1;
`ifdef SHIFT_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_al_in;
  logic [N-1:0] word_in;
  logic         word_valid;
  logic         word_ready, q_out, frame_out, busy, done_out;
  logic [N-1:0] word_in2;
  logic         word_valid2;
  logic         word_ready2, q_out2, frame_out2, busy2, done_out2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.N(N), .GAP(GAP)) dut (
    .clk(clk), .reset_al_in(reset_al_in), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .q_out(q_out), .frame_out(frame_out), .busy(busy),
    .done_out(done_out)
  );

  shift_seq_ctrl #(.N(N), .GAP(0)) dut_g0 (
    .clk(clk), .reset_al_in(reset_al_in), .word_in(word_in2), .word_valid(word_valid2),
    .word_ready(word_ready2), .q_out(q_out2), .frame_out(frame_out2), .busy(busy2),
    .done_out(done_out2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!word_ready && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (!word_ready) begin
      errors++;
      $display("FAIL %s_ready_timeout: word_ready=%b after %0d cycles, required 1", tag, word_ready, n);
    end
  endtask

  task automatic test_reset();
    reset_al_in = 1'b0;
    word_valid = 1'b0; word_in = '0;
    word_valid2 = 1'b0; word_in2 = '0;
    repeat (2) step();
    checks++;
    if ({word_ready, q_out, frame_out, busy, done_out, word_ready2, busy2} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 0000000",
               {word_ready, q_out, frame_out, busy, done_out, word_ready2, busy2});
    end
    reset_al_in = 1'b1;
    checks++;
    if (word_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: word_ready=%b, required 0", word_ready);
    end
    step();
    checks++;
    if ({word_ready, word_ready2, busy} !== 3'b110) begin
      errors++;
      $display("FAIL ready_after_release: {rdy,rdy2,busy}=%b, required 110",
               {word_ready, word_ready2, busy});
    end
  endtask

  // 4'b1011 -> bits 1,1,0,1 then (with parity) 1; value stored with cycle 1 in bit 0.
  task automatic test_single_word();
    logic [4:0] exp_q = 5'b11011;
    logic eq, ef, ed;
    word_in = 4'b1011;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    word_in = 4'b0000;
    for (int c = 1; c <= N + PAR + GAP; c++) begin
      if (c <= N + PAR) begin
        eq = exp_q[c-1]; ef = 1'b1; ed = (c == N + PAR);
      end else begin
        eq = 1'b0; ef = 1'b0; ed = 1'b0;
      end
      checks++;
      if ({q_out, frame_out, done_out, word_ready, busy} !== {eq, ef, ed, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL single_cycle%0d: {q,frame,done,rdy,busy}=%b, required %b",
                 c, {q_out, frame_out, done_out, word_ready, busy}, {eq, ef, ed, 1'b0, 1'b1});
      end
      step();
    end
    checks++;
    if ({word_ready, busy, frame_out, q_out} !== 4'b1000) begin
      errors++;
      $display("FAIL single_return_idle: {rdy,busy,frame,q}=%b, required 1000",
               {word_ready, busy, frame_out, q_out});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_a = 4'b1010;  // bits 0,1,0,1
    logic [3:0] exp_5 = 4'b0101;  // bits 1,0,1,0
    int k = 0;
    bit seen = 0;
    word_in = 4'hA;
    word_valid = 1'b1;
    step();
    word_in = 4'h5;
    for (int c = 1; c <= 20 && !seen; c++) begin
      if (word_ready) begin
        seen = 1; k = c;
      end else begin
        if (c <= N) begin
          checks++;
          if ({q_out, frame_out} !== {exp_a[c-1], 1'b1}) begin
            errors++;
            $display("FAIL b2b_first_bit%0d: {q,frame}=%b, required %b",
                     c - 1, {q_out, frame_out}, {exp_a[c-1], 1'b1});
          end
        end
        step();
      end
    end
    checks++;
    if (!seen || k != N + GAP + 1 + PAR) begin
      errors++;
      $display("FAIL b2b_period: period=%0d seen=%0d, required %0d", k, seen, N + GAP + 1 + PAR);
    end
    step();
    word_valid = 1'b0;
    word_in = 4'h0;
    for (int c = 1; c <= N; c++) begin
      checks++;
      if ({q_out, frame_out} !== {exp_5[c-1], 1'b1}) begin
        errors++;
        $display("FAIL b2b_second_bit%0d: {q,frame}=%b, required %b",
                 c - 1, {q_out, frame_out}, {exp_5[c-1], 1'b1});
      end
      step();
    end
    wait_ready("b2b");
  endtask

  task automatic test_word_toggle();
    logic [3:0] exp_6 = 4'b0110;  // bits 0,1,1,0
    word_in = 4'h6;
    word_valid = 1'b1;
    step();
    for (int c = 1; c <= N; c++) begin
      word_in = ~word_in ^ 4'(c);
      word_valid = c[0];
      checks++;
      if (q_out !== exp_6[c-1]) begin
        errors++;
        $display("FAIL toggle_bit%0d: q=%b, required %b", c - 1, q_out, exp_6[c-1]);
      end
      if (c == N) word_valid = 1'b0;
      step();
    end
    wait_ready("toggle");
  endtask

  // GAP=0 instance with word 4'h3 held: bits 1,1,0,0, parity 0, then one idle cycle.
  task automatic test_gap_zero();
    logic [3:0] exp_3 = 4'b0011;
    int per = N + PAR + 1;
    int p;
    logic eq, ef;
    word_in2 = 4'h3;
    word_valid2 = 1'b1;
    step();
    for (int c = 1; c <= 2 * per; c++) begin
      p = (c - 1) % per;
      ef = (p < N + PAR);
      eq = (p < N) ? exp_3[p] : 1'b0;
      checks++;
      if ({frame_out2, word_ready2, q_out2} !== {ef, ~ef, eq}) begin
        errors++;
        $display("FAIL gap0_cycle%0d: {frame,rdy,q}=%b, required %b",
                 c, {frame_out2, word_ready2, q_out2}, {ef, ~ef, eq});
      end
      if (c == 2 * per) word_valid2 = 1'b0;
      step();
    end
    checks++;
    if ({busy2, word_ready2} !== 2'b01) begin
      errors++;
      $display("FAIL gap0_stop: {busy,rdy}=%b, required 01", {busy2, word_ready2});
    end
  endtask

  task automatic test_reset_mid_word();
    bit saw_done = 0;
    word_in = 4'hF;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      if (done_out) saw_done = 1;
      step();
    end
    checks++;
    if ({q_out, frame_out, busy} !== 3'b111) begin
      errors++;
      $display("FAIL mid_bit2: {q,frame,busy}=%b, required 111", {q_out, frame_out, busy});
    end
    #2 reset_al_in = 1'b0;
    #1;
    checks++;
    if ({word_ready, q_out, frame_out, busy, done_out} !== 5'b0) begin
      errors++;
      $display("FAIL mid_async_reset: {rdy,q,frame,busy,done}=%b, required 00000",
               {word_ready, q_out, frame_out, busy, done_out});
    end
    step();
    if (done_out) saw_done = 1;
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL mid_no_done: done pulse seen=%b, required 0", saw_done);
    end
    reset_al_in = 1'b1;
    checks++;
    if (word_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_ready_at_release: word_ready=%b, required 0", word_ready);
    end
    step();
    checks++;
    if ({word_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL mid_ready_after_release: {rdy,busy}=%b, required 10", {word_ready, busy});
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_word_toggle();
    test_gap_zero();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter N, default 4, meaning serial word width in bits (N >= 2).
REQ-002 Parameter GAP, default 1, meaning idle cycles inserted after each word (0..15).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset_al_in  input  1  asynchronous, active-low reset.
REQ-005 word_in  input  N  parallel word to serialize.
REQ-006 word_valid  input  1  word_in valid; held by source until accepted.
REQ-007 word_ready  output  1  controller can accept a word this cycle.
REQ-008 q_out  output  1  serial data bit, LSB first.
REQ-009 frame_out  output  1  high on every cycle that q_out carries a valid bit.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 done_out  output  1  single-cycle pulse marking the final bit of a word.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, PAR (only with macro), and GAP.
REQ-013 word_ready SHALL be high only in IDLE; an accept is word_valid & word_ready at a posedge.
REQ-014 On accept: capture word_in into an internal N-bit shift register, clear the bit counter, go to SHIFT.
REQ-015 In SHIFT: q_out = shift_reg[0], frame_out = 1; each posedge shifts right by one and increments the counter.
REQ-016 First data bit SHALL appear on q_out in the cycle after accept (latency 1).
REQ-017 After the bit at counter N-1: go to PAR if the macro is defined; otherwise go to GAP, or to IDLE if GAP = 0.
REQ-018 GAP state SHALL last exactly GAP cycles, then go to IDLE; frame_out = 0 and word_ready = 0 throughout.
REQ-019 done_out SHALL be high in the same cycle as the last framed bit of a word, and low otherwise.
REQ-020 q_out SHALL be 0 whenever frame_out = 0.
REQ-021 Word period at continuous word_valid SHALL be N + GAP + 1 cycles (plus 1 with parity).
REQ-022 Changes on word_in or word_valid outside an accept cycle SHALL be ignored; a captured word is never altered.
REQ-023 The counter width SHALL be ceil(log2(N)); counter wrap beyond N-1 SHALL NOT occur.

Reset
REQ-024 Assertion of reset_al_in = 0 SHALL immediately force state IDLE, shift register 0, counter 0, q_out 0, frame_out 0, busy 0, done_out 0, and word_ready 0.
REQ-025 word_ready SHALL rise on the first posedge after reset_al_in deasserts.
REQ-026 Reset mid-word SHALL abort the transfer with no done_out pulse; the word is lost.

Configuration
REQ-027 Macro SHIFT_PARITY_EN defined: after the last data bit, one PAR cycle SHALL drive q_out = XOR of the captured word (even parity), with frame_out = 1 and done_out = 1 in PAR, not on the last data bit.
REQ-028 Macro SHIFT_PARITY_EN undefined: no PAR state, no parity logic, and behaviour as in REQ-017 and REQ-019.

Verification (N=4, GAP=1 unless stated)
REQ-029 Accept 4'b1011 -> q_out 1,1,0,1 on cycles 1..4 after accept; frame_out high on cycles 1..4; done_out on cycle 4; word_ready low for 5 cycles.
REQ-030 word_valid held high with words 4'hA then 4'h5 -> second accept exactly 6 cycles after the first; bit streams 0,1,0,1 then 1,0,1,0.
REQ-031 GAP=0, continuous words -> word period of 5 cycles, with frame_out low for exactly 1 cycle between words.
REQ-032 Reset asserted at bit 2 of 4'hF -> all outputs 0 asynchronously, no done_out, and word_ready high 1 cycle after release.
REQ-033 SHIFT_PARITY_EN defined, accept 4'b1011 -> q_out 1,1,0,1,1; frame_out high 5 cycles; done_out on the 5th bit.
REQ-034 word_in toggled every cycle during SHIFT -> serial output equals the word captured at accept.
